spi_prot_trig: RTL

//  Parametrised SPI protocol trigger for the LA digital core. It watches the
//  SS_n/SCLK/MOSI levels on CH1/CH2/CH3 and captures each SPI frame, MSB first.
//  It asserts a trigger when the captured frame equals a programmed match value

---
 rtl/spi_prot_trig.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/spi_prot_trig.sv
// SPI protocol trigger: captures SS_n-framed MOSI bits MSB first on a selectable
// SCLK edge, reports each frame and pulses a trigger on a masked compare hit.
module spi_prot_trig #(
    parameter  int MAX_WIDTH   = 16,
    parameter  int SYNC_STAGES = 2,
    localparam int LW          = $clog2(MAX_WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 SS_n,
    input  logic                 SCLK,
    input  logic                 MOSI,
    input  logic                 en,
    input  logic                 pos_edge,
    input  logic [LW-1:0]        len,
    input  logic [MAX_WIDTH-1:0] match,
    input  logic [MAX_WIDTH-1:0] mask,
    input  logic                 clr,
    output logic [MAX_WIDTH-1:0] rx_data,
    output logic                 rx_vld,
    output logic                 trig,
    output logic                 trigd,
    output logic                 ovr
);
    localparam int CW = $clog2(MAX_WIDTH + 2);
    localparam logic [CW-1:0] CNT_SAT = CW'(MAX_WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t                 r_state, w_next;
    logic [SYNC_STAGES-1:0] r_ss_sync, r_sclk_sync, r_mosi_sync;
    logic                   r_ss_d, r_sclk_d;
    logic                   r_ss_fall, r_ss_rise, r_strobe, r_mosi_s, r_fall_pend;
    logic [MAX_WIDTH-1:0]   r_shift;
    logic [CW-1:0]          r_bit_cnt;
    logic                   w_ss, w_sclk, w_mosi;
    logic [MAX_WIDTH-1:0]   w_lmask;
    logic                   w_len_ok, w_hit;

    assign w_ss   = r_ss_sync[SYNC_STAGES-1];
    assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    // Edge flags are registered so MOSI, strobe and SS_n edges stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ss_sync   <= '1;
            r_sclk_sync <= '1;
            r_mosi_sync <= '0;
            r_ss_d      <= 1'b1;
            r_sclk_d    <= 1'b1;
            r_ss_fall   <= 1'b0;
            r_ss_rise   <= 1'b0;
            r_strobe    <= 1'b0;
            r_mosi_s    <= 1'b0;
            r_fall_pend <= 1'b0;
        end else begin
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS_n};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_ss_d      <= w_ss;
            r_sclk_d    <= w_sclk;
            r_ss_fall   <= r_ss_d & ~w_ss;
            r_ss_rise   <= ~r_ss_d & w_ss;
            r_strobe    <= ~w_ss & (pos_edge ? (~r_sclk_d & w_sclk) : (r_sclk_d & ~w_sclk));
            r_mosi_s    <= w_mosi;
            // A select fall landing in DONE is replayed into the next IDLE cycle.
            r_fall_pend <= r_ss_fall & (r_state == S_DONE);
        end
    end

    always_comb begin
        w_lmask = '0;
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            w_lmask[i] = (i < 32'(len));
        end
        w_len_ok = (len != '0) && (32'(len) <= 32'(MAX_WIDTH)) && (32'(r_bit_cnt) == 32'(len));
        w_hit    = (((r_shift ^ match) & ~mask & w_lmask) == '0);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (en && (r_ss_fall || r_fall_pend)) w_next = S_SHIFT;
            S_SHIFT: begin
                if (!en)            w_next = S_IDLE;
                else if (r_ss_rise) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            rx_data   <= '0;
            rx_vld    <= 1'b0;
            trig      <= 1'b0;
            trigd     <= 1'b0;
            ovr       <= 1'b0;
        end else begin
            r_state <= w_next;
            rx_vld  <= 1'b0;
            trig    <= 1'b0;
            if (clr) begin
                trigd <= 1'b0;
                ovr   <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_next == S_SHIFT) begin
                        r_shift   <= '0;
                        r_bit_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    if (en && r_strobe) begin
                        r_shift <= {r_shift[MAX_WIDTH-2:0], r_mosi_s};
                        if (r_bit_cnt != CNT_SAT) r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (w_len_ok) begin
                        rx_data <= r_shift & w_lmask;
                        rx_vld  <= 1'b1;
                        if (w_hit) begin
                            trig  <= 1'b1;
                            trigd <= 1'b1;
                        end
                    end else begin
                        ovr <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
